// File: rtl/ctx_spill_engine.sv
// Context spill/fill engine: streams registers FIRST_REG..NUM_REGS-1 from the
// register bank into a memory block (save), or reads that block back into the
// register bank through a two-stage read/write pipeline (restore/fill).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for Save_Req / Restore_Req, all strobes low
// SAVE  | one register read + one memory write per cycle
// FILL  | stage 1 presents memory reads, stage 2 writes returned data to RF
// DONE  | one-cycle Done pulse, requests ignored, then back to IDLE
module ctx_spill_engine #(
    parameter int NUM_REGS  = 64,
    parameter int FIRST_REG = 1,
    parameter int ADDR_W    = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Save_Req,
    input  logic              Restore_Req,
    input  logic [ADDR_W-1:0] Base_Addr,
    output logic              Busy,
    output logic              Done,
    output logic [5:0]        Rf_Addr,
    input  logic [31:0]       Rf_RData,
    output logic              Rf_Write,
    output logic [5:0]        Rf_WAddr,
    output logic [31:0]       Rf_WData,
    output logic              Mem_Write,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_WData,
    input  logic [31:0]       Mem_RData
);

    // Register 0 must never be written, and indices must fit the 6-bit port.
    if (FIRST_REG < 1 || FIRST_REG >= NUM_REGS || NUM_REGS > 64 || ADDR_W <= 6) begin : g_param_check
        $error("ctx_spill_engine: illegal FIRST_REG/NUM_REGS/ADDR_W combination");
    end

    localparam logic [5:0] FIRST_IDX = 6'(FIRST_REG);
    localparam logic [5:0] LAST_IDX  = 6'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        FILL,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [5:0]        idx, idx_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic              rd_done, rd_done_nxt;
    logic              wr_vld, wr_vld_nxt;
    logic [5:0]        wr_idx, wr_idx_nxt;

    logic [5:0]        offset;
    logic [ADDR_W-1:0] blk_addr;

    // Block offset is 6 bits, zero-extended; the add wraps at 2^ADDR_W.
    assign offset   = idx - FIRST_IDX;
    assign blk_addr = base + {{(ADDR_W-6){1'b0}}, offset};

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            idx     <= '0;
            base    <= '0;
            rd_done <= 1'b0;
            wr_vld  <= 1'b0;
            wr_idx  <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            base    <= base_nxt;
            rd_done <= rd_done_nxt;
            wr_vld  <= wr_vld_nxt;
            wr_idx  <= wr_idx_nxt;
        end
    end

    // Next-state logic and decoded outputs.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        base_nxt    = base;
        rd_done_nxt = rd_done;
        wr_vld_nxt  = wr_vld;
        wr_idx_nxt  = wr_idx;

        Busy      = 1'b0;
        Done      = 1'b0;
        Rf_Addr   = '0;
        Rf_Write  = 1'b0;
        Rf_WAddr  = '0;
        Rf_WData  = '0;
        Mem_Write = 1'b0;
        Mem_Addr  = '0;
        Mem_WData = '0;

        case (state)
            IDLE: begin
                // Save has priority; a simultaneous restore request is dropped.
                if (Save_Req) begin
                    base_nxt  = Base_Addr;
                    idx_nxt   = FIRST_IDX;
                    state_nxt = SAVE;
                end else if (Restore_Req) begin
                    base_nxt    = Base_Addr;
                    idx_nxt     = FIRST_IDX;
                    rd_done_nxt = 1'b0;
                    wr_vld_nxt  = 1'b0;
                    state_nxt   = FILL;
                end
            end

            SAVE: begin
                Busy      = 1'b1;
                Rf_Addr   = idx;
                Mem_Write = 1'b1;
                Mem_Addr  = blk_addr;
                Mem_WData = Rf_RData;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + 6'd1;
                end
            end

            FILL: begin
                Busy       = 1'b1;
                wr_vld_nxt = 1'b0;
                // Stage 1: issue the read; its data returns next cycle.
                if (!rd_done) begin
                    Mem_Addr   = blk_addr;
                    wr_vld_nxt = 1'b1;
                    wr_idx_nxt = idx;
                    if (idx == LAST_IDX) begin
                        rd_done_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + 6'd1;
                    end
                end
                // Stage 2: commit the returned word to the register bank.
                if (wr_vld) begin
                    Rf_Write = 1'b1;
                    Rf_WAddr = wr_idx;
                    Rf_WData = Mem_RData;
                    if (wr_idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                Busy        = 1'b1;
                Done        = 1'b1;
                rd_done_nxt = 1'b0;
                wr_vld_nxt  = 1'b0;
                state_nxt   = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctx_spill_engine.sv
// Directed bench for ctx_spill_engine: register-bank and memory models, a
// table of save/restore transactions, and hand sequences for reset abort,
// address wrap and a permanently held restore request.
module tb_ctx_spill_engine;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Save_Req = 1'b0;
    logic        Restore_Req = 1'b0;
    logic [31:0] Base_Addr = 32'h0;
    logic        Busy, Done, Rf_Write, Mem_Write;
    logic [5:0]  Rf_Addr, Rf_WAddr;
    logic [31:0] Rf_RData, Rf_WData, Mem_Addr, Mem_WData, Mem_RData;

    ctx_spill_engine #(.NUM_REGS(64), .FIRST_REG(1), .ADDR_W(32)) dut (
        .Clock(Clock), .Reset(Reset),
        .Save_Req(Save_Req), .Restore_Req(Restore_Req), .Base_Addr(Base_Addr),
        .Busy(Busy), .Done(Done),
        .Rf_Addr(Rf_Addr), .Rf_RData(Rf_RData),
        .Rf_Write(Rf_Write), .Rf_WAddr(Rf_WAddr), .Rf_WData(Rf_WData),
        .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Mem_RData(Mem_RData)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int failed = 0;

    logic [31:0] rf [64];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] mem_rdata = 32'h0;
    int          mw_total = 0;
    logic        do_preload = 1'b0;

    assign Rf_RData  = rf[Rf_Addr];
    assign Mem_RData = mem_rdata;

    // Register bank and memory models (memory read data lags the address by one cycle).
    always @(posedge Clock) begin
        if (do_preload) begin
            for (int i = 0; i < 64; i++) rf[i] = (i == 0) ? 32'hDEAD0000 : 32'h100 + 32'(i);
            mem.delete();
            for (int k = 0; k < 63; k++) mem[32'h3000 + 32'(k)] = 32'hA0000000 + 32'(k);
            mw_total = 0;
        end else begin
            if (Rf_Write) rf[Rf_WAddr] = Rf_WData;
            if (Mem_Write) begin
                mem[Mem_Addr] = Mem_WData;
                mw_total++;
            end
        end
        mem_rdata <= mem.exists(Mem_Addr) ? mem[Mem_Addr] : 32'h0;
    end

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hBADBAD00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload();
        @(negedge Clock);
        do_preload = 1'b1;
        @(posedge Clock);
        #1 do_preload = 1'b0;
    endtask

    // One transaction; k counts cycles after the accepting edge N.
    task automatic run_txn(input bit sv, input bit rs, input logic [31:0] base,
                           output int lat, output int mw, output int rw,
                           output int err, output int post);
        @(negedge Clock);
        Save_Req = sv; Restore_Req = rs; Base_Addr = base;
        lat = -1; mw = 0; rw = 0; err = 0; post = 0;
        for (int k = 1; k <= 90; k++) begin
            @(negedge Clock);
            if (k == 1) begin
                Save_Req = 1'b0; Restore_Req = 1'b0; Base_Addr = ~base;
            end
            if (Busy !== 1'b1) err++;
            if (Mem_Write) begin
                mw++;
                if (k > 63 || Mem_Addr !== base + 32'(k - 1) || Mem_WData !== 32'h100 + 32'(k)) err++;
            end
            if (Rf_Write) begin
                rw++;
                if (k < 2 || k > 64 || Rf_WAddr !== 6'(k - 1) ||
                    Rf_WData !== 32'hA0000000 + 32'(k - 2)) err++;
            end
            if (Done) begin
                lat = k;
                @(negedge Clock);
                post = (Busy === 1'b0 && Done === 1'b0 && Mem_Write === 1'b0 && Rf_Write === 1'b0) ? 1 : 0;
                break;
            end
        end
    endtask

    typedef struct {
        bit          sv;
        bit          rs;
        logic [31:0] base;
        int          exp_lat;
        int          exp_mw;
        int          exp_rw;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int lat, mw, rw, err, post;
        int d1, d2, idle_gap, hits;

        vecs[0] = '{1'b1, 1'b0, 32'h00002000, 64, 63, 0};
        vecs[1] = '{1'b0, 1'b1, 32'h00003000, 65, 0, 63};
        vecs[2] = '{1'b1, 1'b1, 32'h00002000, 64, 63, 0};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFFFFF0, 64, 63, 0};
        vecs[4] = '{1'b1, 1'b0, 32'h00005555, 64, 63, 0};

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_rf_write", 32'(Rf_Write), 32'h0);
        chk("rst_mem_write", 32'(Mem_Write), 32'h0);
        chk("rst_rf_addr", 32'(Rf_Addr), 32'h0);
        chk("rst_rf_waddr", 32'(Rf_WAddr), 32'h0);
        chk("rst_rf_wdata", Rf_WData, 32'h0);
        chk("rst_mem_addr", Mem_Addr, 32'h0);
        chk("rst_mem_wdata", Mem_WData, 32'h0);
        Reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            preload();
            run_txn(vecs[v].sv, vecs[v].rs, vecs[v].base, lat, mw, rw, err, post);
            chk($sformatf("v%0d_done_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("v%0d_mem_writes", v), 32'(mw), 32'(vecs[v].exp_mw));
            chk($sformatf("v%0d_rf_writes", v), 32'(rw), 32'(vecs[v].exp_rw));
            chk($sformatf("v%0d_cycle_errs", v), 32'(err), 32'h0);
            chk($sformatf("v%0d_idle_after", v), 32'(post), 32'h1);
            chk($sformatf("v%0d_rf0", v), rf[0], 32'hDEAD0000);
        end

        // Address wrap: register 17 lands on address 0.
        preload();
        run_txn(1'b1, 1'b0, 32'hFFFFFFF0, lat, mw, rw, err, post);
        chk("wrap_r17_at_0", memrd(32'h00000000), 32'h111);
        chk("wrap_r16_at_top", memrd(32'hFFFFFFFF), 32'h110);
        chk("wrap_r63_at_2e", memrd(32'h0000002E), 32'h13F);

        // Reset during cycle N+20 of a save.
        preload();
        @(negedge Clock);
        Save_Req = 1'b1; Base_Addr = 32'h2000;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clock);
            if (k == 1) Save_Req = 1'b0;
        end
        Reset = 1'b1;
        @(negedge Clock);
        chk("abort_busy", 32'(Busy), 32'h0);
        chk("abort_mem_write", 32'(Mem_Write), 32'h0);
        Reset = 1'b0;
        hits = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge Clock);
            if (Done || Mem_Write || Busy || Rf_Write) hits++;
        end
        chk("abort_quiet", 32'(hits), 32'h0);
        chk("abort_write_count", 32'(mw_total), 32'd20);
        chk("abort_last_write", memrd(32'h2000 + 32'd19), 32'h114);
        chk("abort_no_write20", 32'(mem.exists(32'h2000 + 32'd20)), 32'h0);

        // Restore request held high: back-to-back restores.
        preload();
        @(negedge Clock);
        Restore_Req = 1'b1; Base_Addr = 32'h3000;
        d1 = -1; d2 = -1; idle_gap = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge Clock);
            if (d1 >= 0 && !Busy) idle_gap++;
            if (Done) begin
                if (d1 < 0) d1 = k;
                else begin
                    d2 = k;
                    break;
                end
            end
        end
        chk("held_first_done", 32'(d1), 32'd65);
        chk("held_done_spacing", 32'(d2 - d1), 32'd66);
        chk("held_idle_cycles", 32'(idle_gap), 32'd1);
        chk("held_rf0", rf[0], 32'hDEAD0000);
        chk("held_rf63", rf[63], 32'hA000003E);
        Restore_Req = 1'b0;
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ctx_spill_engine.md
# ctx_spill_engine

Context spill/fill engine for the processor's 64-entry register bank. On a save request it reads registers FIRST_REG..NUM_REGS-1 in order through a register-file read port and streams them into data memory at a base address. On a restore request it reads the same memory block back and writes each word into the register bank. It sits between the OS context-switch control logic, the register file and the data-memory port, and owns both while busy.

## Interface
Parameters:
- NUM_REGS, 64, number of registers in the bank (index width 6)
- FIRST_REG, 1, first register transferred; register 0 is never read or written
- ADDR_W, 32, memory address width

Ports:
- Clock  in  1  single clock; all state changes on the rising edge
- Reset  in  1  reset Reset, synchronous, active-high
- Save_Req  in  1  start a save; sampled only in IDLE
- Restore_Req  in  1  start a restore; sampled only in IDLE
- Base_Addr  in  ADDR_W  memory base of the context block; latched when a request is accepted
- Busy  out  1  engine owns the register file and memory port
- Done  out  1  one-cycle pulse when a transfer completes
- Rf_Addr  out  6  register-file read index
- Rf_RData  in  32  register-file read data, combinational from Rf_Addr
- Rf_Write  out  1  register-file write strobe
- Rf_WAddr  out  6  register-file write index
- Rf_WData  out  32  register-file write data
- Mem_Write  out  1  memory write strobe
- Mem_Addr  out  ADDR_W  memory address
- Mem_WData  out  32  memory write data
- Mem_RData  in  32  memory read data, valid one cycle after Mem_Addr is presented

## Operation
- States: IDLE, SAVE, FILL, DONE.
- IDLE: Busy=0 and all strobes 0. If Save_Req=1, latch Base_Addr, set idx=FIRST_REG and go to SAVE. Otherwise, if Restore_Req=1, do the same and go to FILL. If both are asserted, save wins and the restore request is dropped.
- SAVE, one register per cycle:
  - Rf_Addr=idx, Mem_Write=1, Mem_Addr=base+(idx-FIRST_REG), Mem_WData=Rf_RData.
  - After the idx=NUM_REGS-1 write, go to DONE.
- FILL is a two-stage pipeline:
  - Stage 1 presents Mem_Addr=base+(idx-FIRST_REG) with Mem_Write=0 and advances idx each cycle until NUM_REGS-1.
  - Stage 2, one cycle later, drives Rf_Write=1, Rf_WAddr=the delayed idx and Rf_WData=Mem_RData.
  - Go to DONE after the last stage-2 write.
- DONE: Done=1 and Busy=1 for one cycle, then IDLE. Requests asserted in DONE are ignored.
- Address arithmetic wraps modulo 2^ADDR_W. The offset width is 6 bits, zero-extended.
- Rf_WAddr is never 0: FIRST_REG≥1 is enforced by a parameter check.
- Requests held high continuously re-trigger once per return to IDLE.

## Timing
- Reset values: state=IDLE, Busy=0, Done=0, Rf_Write=0, Mem_Write=0; Rf_Addr, Rf_WAddr, Mem_Addr, Rf_WData and Mem_WData all 0.
- Request accepted at edge N:
  - Busy is high from N+1 through the DONE cycle.
  - Save writes memory on cycles N+1..N+(NUM_REGS-FIRST_REG), i.e. 63 writes by default, and Done is high at N+64.
  - Restore issues reads on N+1..N+63 and register writes on N+2..N+64, and Done is high at N+65.
- Reset asserted mid-transfer: at the next edge the engine is in IDLE with all strobes 0. No partial write is completed after that edge, and no Done pulse is produced.
- Base_Addr changes while Busy have no effect.

## Test plan
- Load regs 1..63 with value 0x100+i, Base_Addr=0x2000, pulse Save_Req → 63 memory writes, addr 0x2000+i-1 with data 0x100+i, cycles N+1..N+63; Done at N+64; no Mem_Write at any other cycle.
- Memory preloaded at 0x3000+k with 0xA0000000+k, pulse Restore_Req → Rf_Write at N+2..N+64, Rf_WAddr=k+1 with data 0xA0000000+k; register 0 is never written; Done at N+65.
- Save_Req and Restore_Req asserted in the same cycle → save sequence only; no Rf_Write is ever asserted.
- Reset asserted at cycle N+20 of a save → Mem_Write=0 and Busy=0 from N+21; no Done pulse; memory shows writes 0..19 only.
- Base_Addr=0xFFFFFFF0 with save → addresses wrap, and register 17 is written to address 0x00000000.
- Restore_Req held high permanently → back-to-back restores separated by exactly one IDLE cycle after each Done.
